// File: rtl/br_resolve_if.sv
// Branch-prediction consumer bus: fetch lookup, resolve inputs, predictor update and stats.
// master drives fetch/predictor/resolve inputs; slave is br_resolve_unit.
interface br_resolve_if #(
  parameter int IDXW = 3,
  parameter int CNTW = 16
);
  logic            pc_en;
  logic [31:0]     fetch_pc;
  logic            fetch_is_br;
  logic [IDXW-1:0] bp_index;
  logic            bp_predict;
  logic [31:0]     bp_target;
  logic [31:0]     npc;
  logic            fetch_stall;
  logic            res_valid;
  logic            res_taken;
  logic [31:0]     res_target;
  logic            flush;
  logic [31:0]     redirect_pc;
  logic            upd_br;
  logic [IDXW-1:0] upd_index;
  logic            upd_taken;
  logic [31:0]     upd_target;
  logic [CNTW-1:0] br_count;
  logic [CNTW-1:0] mp_count;
  logic            q_err;

  modport master (
    output pc_en, fetch_pc, fetch_is_br, bp_predict, bp_target,
           res_valid, res_taken, res_target,
    input  bp_index, npc, fetch_stall, flush, redirect_pc,
           upd_br, upd_index, upd_taken, upd_target,
           br_count, mp_count, q_err
  );

  modport slave (
    input  pc_en, fetch_pc, fetch_is_br, bp_predict, bp_target,
           res_valid, res_taken, res_target,
    output bp_index, npc, fetch_stall, flush, redirect_pc,
           upd_br, upd_index, upd_taken, upd_target,
           br_count, mp_count, q_err
  );
endinterface

// File: rtl/br_resolve_unit.sv
// Branch resolve unit: predictor lookup at fetch, in-order in-flight queue,
// mispredict detection with one-cycle flush/recover, predictor update and statistics.
module br_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int IDXW  = 3,
  parameter int CNTW  = 16
) (
  input  logic          CLK,
  input  logic          nRST,
  br_resolve_if.slave   bus
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {RUN, RECOVER} state_e;

  state_e          state_q;
  logic [PW:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]     wr_ptr_d, rd_ptr_d;
  logic            flush_q;
  logic [31:0]     redirect_pc_q;
  logic            upd_br_q;
  logic [IDXW-1:0] upd_index_q;
  logic            upd_taken_q;
  logic [31:0]     upd_target_q;
  logic [CNTW-1:0] br_count_q, mp_count_q;
  logic            q_err_q;

  logic [IDXW-1:0] q_idx_q [DEPTH];
  logic            q_tkn_q [DEPTH];
  logic [31:0]     q_tgt_q [DEPTH];
  logic [31:0]     q_ft_q  [DEPTH];

  logic            empty, full, run, pop, push, mispredict;
  logic [PW-1:0]   rd_slot, wr_slot;
  logic [31:0]     fallthru;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + {{(CNTW-1){1'b0}}, 1'b1};
  endfunction

  // Extra pointer MSB distinguishes full from empty when the slot bits match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign run     = (state_q == RUN);
  assign rd_slot = rd_ptr_q[PW-1:0];
  assign wr_slot = wr_ptr_q[PW-1:0];
  assign fallthru = bus.fetch_pc + 32'd4;

  assign pop  = bus.res_valid & ~empty & run;
  assign push = bus.fetch_is_br & bus.pc_en & (~full | pop) & run & ~flush_q;

  // A taken prediction to the wrong target is as bad as a wrong direction.
  assign mispredict = pop &
    ((q_tkn_q[rd_slot] != bus.res_taken) |
     (q_tkn_q[rd_slot] & bus.res_taken & (q_tgt_q[rd_slot] != bus.res_target)));

  assign wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop};

  assign bus.bp_index    = bus.fetch_pc[IDXW+1:2];
  assign bus.fetch_stall = full;

  always_comb begin
    bus.npc = fallthru;
    if (flush_q)
      bus.npc = redirect_pc_q;
    else if (full)
      bus.npc = bus.fetch_pc;
    else if (bus.fetch_is_br & bus.bp_predict)
      bus.npc = bus.bp_target;
  end

  // Queue payload is not reset; validity comes solely from the pointers.
  always_ff @(posedge CLK) begin
    if (push) begin
      q_idx_q[wr_slot] <= bus.fetch_pc[IDXW+1:2];
      q_tkn_q[wr_slot] <= bus.bp_predict;
      q_tgt_q[wr_slot] <= bus.bp_target;
      q_ft_q[wr_slot]  <= fallthru;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= RUN;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      upd_br_q      <= 1'b0;
      upd_index_q   <= '0;
      upd_taken_q   <= 1'b0;
      upd_target_q  <= '0;
      br_count_q    <= '0;
      mp_count_q    <= '0;
      q_err_q       <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (mispredict) begin
            // Everything younger is wrong-path, including a same-cycle push.
            state_q       <= RECOVER;
            flush_q       <= 1'b1;
            redirect_pc_q <= bus.res_taken ? bus.res_target : q_ft_q[rd_slot];
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
          end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
          end
        end
        RECOVER: state_q <= RUN;
        default: state_q <= RUN;
      endcase

      if (bus.res_valid & empty & run)
        q_err_q <= 1'b1;

      if (pop) begin
        upd_br_q     <= 1'b1;
        upd_index_q  <= q_idx_q[rd_slot];
        upd_taken_q  <= bus.res_taken;
        upd_target_q <= bus.res_taken ? bus.res_target : q_tgt_q[rd_slot];
        br_count_q   <= sat_inc(br_count_q);
        if (mispredict)
          mp_count_q <= sat_inc(mp_count_q);
      end else if (upd_br_q & bus.pc_en) begin
        upd_br_q <= 1'b0;
      end
    end
  end

  assign bus.flush       = flush_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.upd_br      = upd_br_q;
  assign bus.upd_index   = upd_index_q;
  assign bus.upd_taken   = upd_taken_q;
  assign bus.upd_target  = upd_target_q;
  assign bus.br_count    = br_count_q;
  assign bus.mp_count    = mp_count_q;
  assign bus.q_err       = q_err_q;

endmodule

// File: tb/tb_br_resolve_unit.sv
// Directed bench for br_resolve_unit: hit/miss resolve, recover, full queue,
// pointer wrap, empty-queue error, held updates and asynchronous reset.
module tb_br_resolve_unit;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   checks = 0;
  int   failures = 0;

  br_resolve_if #(.IDXW(3), .CNTW(16)) bus ();

  br_resolve_unit #(.DEPTH(4), .IDXW(3), .CNTW(16)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic br, input logic pred,
                       input logic [31:0] tgt);
    bus.fetch_pc    = pc;
    bus.fetch_is_br = br;
    bus.bp_predict  = pred;
    bus.bp_target   = tgt;
  endtask

  task automatic resolve(input logic v, input logic tkn, input logic [31:0] tgt);
    bus.res_valid  = v;
    bus.res_taken  = tkn;
    bus.res_target = tgt;
  endtask

  initial begin
    logic [31:0] p;
    bus.pc_en = 1'b1;
    fetch(32'h0, 1'b0, 1'b0, 32'h0);
    resolve(1'b0, 1'b0, 32'h0);

    // Reset state
    #12;
    chk("rst_flush", bus.flush, 0);
    chk("rst_redirect", bus.redirect_pc, 0);
    chk("rst_upd_br", bus.upd_br, 0);
    chk("rst_upd_index", bus.upd_index, 0);
    chk("rst_upd_target", bus.upd_target, 0);
    chk("rst_br_count", bus.br_count, 0);
    chk("rst_mp_count", bus.mp_count, 0);
    chk("rst_q_err", bus.q_err, 0);
    chk("rst_stall", bus.fetch_stall, 0);
    @(negedge CLK);
    nRST = 1'b1;
    step();

    // Correctly predicted taken branch
    fetch(32'h40, 1'b1, 1'b1, 32'h100);
    #1;
    chk("t1_bp_index", bus.bp_index, 0);
    chk("t1_npc", bus.npc, 32'h100);
    step();
    fetch(32'h100, 1'b0, 1'b0, 32'h0);
    resolve(1'b1, 1'b1, 32'h100);
    step();
    resolve(1'b0, 1'b0, 32'h0);
    chk("t1_flush", bus.flush, 0);
    chk("t1_upd_br", bus.upd_br, 1);
    chk("t1_upd_index", bus.upd_index, 0);
    chk("t1_upd_taken", bus.upd_taken, 1);
    chk("t1_upd_target", bus.upd_target, 32'h100);
    chk("t1_br_count", bus.br_count, 1);
    chk("t1_mp_count", bus.mp_count, 0);

    // Predicted not-taken, actually taken
    fetch(32'h44, 1'b1, 1'b0, 32'h999);
    #1;
    chk("t2_npc", bus.npc, 32'h48);
    chk("t2_bp_index", bus.bp_index, 1);
    step();
    fetch(32'h48, 1'b0, 1'b0, 32'h0);
    resolve(1'b1, 1'b1, 32'h200);
    step();
    resolve(1'b0, 1'b0, 32'h0);
    chk("t2_flush", bus.flush, 1);
    chk("t2_redirect", bus.redirect_pc, 32'h200);
    chk("t2_npc_redirect", bus.npc, 32'h200);
    chk("t2_mp_count", bus.mp_count, 1);
    chk("t2_br_count", bus.br_count, 2);
    chk("t2_upd_index", bus.upd_index, 1);
    chk("t2_upd_target", bus.upd_target, 32'h200);
    // RECOVER cycle: push and resolve both ignored
    fetch(32'h200, 1'b1, 1'b0, 32'h0);
    resolve(1'b1, 1'b1, 32'h4C);
    step();
    chk("t2_flush_one_cycle", bus.flush, 0);
    chk("t2_recover_no_qerr", bus.q_err, 0);
    chk("t2_recover_br_count", bus.br_count, 2);
    // Queue must still be empty: a resolve now is an error
    fetch(32'h204, 1'b0, 1'b0, 32'h0);
    resolve(1'b1, 1'b1, 32'h4C);
    step();
    resolve(1'b0, 1'b0, 32'h0);
    chk("t5_q_err", bus.q_err, 1);
    chk("t5_br_count", bus.br_count, 2);
    chk("t5_mp_count", bus.mp_count, 1);
    chk("t5_no_flush", bus.flush, 0);
    step();
    chk("t5_q_err_sticky", bus.q_err, 1);

    // Predicted taken, actually not taken
    fetch(32'h50, 1'b1, 1'b1, 32'h80);
    step();
    fetch(32'h80, 1'b0, 1'b0, 32'h0);
    resolve(1'b1, 1'b0, 32'hDEAD);
    step();
    resolve(1'b0, 1'b0, 32'h0);
    chk("t3_flush", bus.flush, 1);
    chk("t3_redirect", bus.redirect_pc, 32'h54);
    chk("t3_upd_taken", bus.upd_taken, 0);
    chk("t3_upd_target", bus.upd_target, 32'h80);
    chk("t3_upd_index", bus.upd_index, 4);
    chk("t3_mp_count", bus.mp_count, 2);
    chk("t3_br_count", bus.br_count, 3);
    step();
    chk("t3_flush_clear", bus.flush, 0);

    // Fill the queue
    for (int k = 0; k < 4; k++) begin
      p = 32'h100 + 32'(4 * k);
      fetch(p, 1'b1, 1'b0, p + 32'h1000);
      step();
    end
    fetch(32'h110, 1'b1, 1'b0, 32'h1110);
    #1;
    chk("t4_stall_full", bus.fetch_stall, 1);
    chk("t4_npc_hold", bus.npc, 32'h110);
    // Push and pop together at full
    resolve(1'b1, 1'b0, 32'h0);
    step();
    chk("t4_full_pushpop_stall", bus.fetch_stall, 1);
    chk("t4_full_pop_index", bus.upd_index, 0);
    chk("t4_full_pop_target", bus.upd_target, 32'h1100);
    chk("t4_br_count", bus.br_count, 4);
    // Eight more push/pop pairs wrap both pointers
    for (int j = 1; j <= 8; j++) begin
      p = 32'h110 + 32'(4 * j);
      fetch(p, 1'b1, 1'b0, p + 32'h1000);
      resolve(1'b1, 1'b0, 32'h0);
      step();
      p = 32'h100 + 32'(4 * j);
      chk("t4_wrap_target", bus.upd_target, p + 32'h1000);
      chk("t4_wrap_index", bus.upd_index, {29'd0, p[4:2]});
      chk("t4_wrap_stall", bus.fetch_stall, 1);
    end
    fetch(32'h300, 1'b0, 1'b0, 32'h0);
    for (int j = 9; j <= 12; j++) begin
      resolve(1'b1, 1'b0, 32'h0);
      step();
      p = 32'h100 + 32'(4 * j);
      chk("t4_drain_target", bus.upd_target, p + 32'h1000);
    end
    resolve(1'b0, 1'b0, 32'h0);
    chk("t4_drain_stall", bus.fetch_stall, 0);
    chk("t4_drain_br_count", bus.br_count, 16);
    chk("t4_drain_mp_count", bus.mp_count, 2);

    // Taken both ways but to a different target
    fetch(32'h200, 1'b1, 1'b1, 32'h300);
    step();
    fetch(32'h300, 1'b0, 1'b0, 32'h0);
    resolve(1'b1, 1'b1, 32'h304);
    step();
    resolve(1'b0, 1'b0, 32'h0);
    chk("t7_flush", bus.flush, 1);
    chk("t7_redirect", bus.redirect_pc, 32'h304);
    chk("t7_mp_count", bus.mp_count, 3);
    chk("t7_br_count", bus.br_count, 17);
    step();

    // Update held while the pipeline is stalled
    fetch(32'h6C, 1'b1, 1'b1, 32'h90);
    step();
    fetch(32'h90, 1'b0, 1'b0, 32'h0);
    bus.pc_en = 1'b0;
    resolve(1'b1, 1'b1, 32'h90);
    step();
    resolve(1'b0, 1'b0, 32'h0);
    chk("t6_upd_br", bus.upd_br, 1);
    chk("t6_flush", bus.flush, 0);
    chk("t6_br_count", bus.br_count, 18);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_hold_upd_br", bus.upd_br, 1);
      chk("t6_hold_index", bus.upd_index, 3);
      chk("t6_hold_target", bus.upd_target, 32'h90);
    end
    bus.pc_en = 1'b1;
    step();
    chk("t6_upd_br_clear", bus.upd_br, 0);

    // Asynchronous reset during a flush with a pending update
    fetch(32'h70, 1'b1, 1'b0, 32'h0);
    step();
    fetch(32'h74, 1'b0, 1'b0, 32'h0);
    resolve(1'b1, 1'b1, 32'h400);
    step();
    resolve(1'b0, 1'b0, 32'h0);
    chk("t8_flush_pre", bus.flush, 1);
    chk("t8_upd_br_pre", bus.upd_br, 1);
    #2;
    nRST = 1'b0;
    #1;
    chk("t8_flush_rst", bus.flush, 0);
    chk("t8_upd_br_rst", bus.upd_br, 0);
    chk("t8_br_count_rst", bus.br_count, 0);
    chk("t8_mp_count_rst", bus.mp_count, 0);
    chk("t8_q_err_rst", bus.q_err, 0);
    chk("t8_redirect_rst", bus.redirect_pc, 0);
    chk("t8_npc_rst", bus.npc, 32'h78);
    @(negedge CLK);
    nRST = 1'b1;
    step();
    chk("t8_flush_after", bus.flush, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
